branch_target_buffer: RTL and testbench

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

---
 rtl/branch_target_buffer.sv | 135 +++++++++++++
 tb/tb_branch_target_buffer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// ============================================================================
// Module      : branch_target_buffer
// Description : Direct-mapped BTB with 2-bit saturating direction counters,
//               zero-latency lookup and saturating update statistics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_target_buffer #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] lk_pc,
  output logic              lk_hit,
  output logic              lk_taken,
  output logic [ADDR_W-1:0] lk_target,
  input  logic              upd_en,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_mispred,
  input  logic              flush,
  output logic [STAT_W-1:0] upd_cnt,
  output logic [STAT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [ADDR_W-1:0]  target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];

  logic [STAT_W-1:0] upd_cnt_q, upd_cnt_d;
  logic [STAT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             upd_hit;

  // Byte-offset bits of a word-aligned PC carry no information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lk_pc[1:0], upd_pc[1:0]};

  assign lk_idx  = lk_pc[IDX_W+1:2];
  assign lk_tag  = lk_pc[ADDR_W-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];

  // Lookup reads the registered array only, so a same-cycle update is not bypassed.
  always_comb begin
    lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_taken  = lk_hit && ctr_q[lk_idx][1];
    lk_target = lk_hit ? target_q[lk_idx] : '0;
  end

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;

    if (flush) begin
      valid_d = '0;
    end else if (upd_en) begin
      if (upd_hit) begin
        if (upd_taken) begin
          target_d[upd_idx] = upd_target;
          if (ctr_q[upd_idx] != CTR_ST) begin
            ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
          end
        end else if (ctr_q[upd_idx] != CTR_SNT) begin
          ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        // Allocation evicts whatever occupied this index.
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target;
        ctr_d[upd_idx]    = CTR_WT;
      end
    end
  end

  // Statistics keep counting through a flush.
  always_comb begin
    upd_cnt_d     = upd_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd_en && (upd_cnt_q != '1)) begin
      upd_cnt_d = upd_cnt_q + STAT_W'(1);
    end
    if (upd_en && upd_mispred && (mispred_cnt_q != '1)) begin
      mispred_cnt_d = mispred_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '0;
      upd_cnt_q     <= '0;
      mispred_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_SNT;
      end
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      target_q      <= target_d;
      ctr_q         <= ctr_d;
      upd_cnt_q     <= upd_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign upd_cnt     = upd_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_target_buffer.sv
// ============================================================================
// Module      : tb_branch_target_buffer
// Description : Directed-vector bench for branch_target_buffer (ENTRIES=16),
//               plus a STAT_W=2 instance for counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] lk_pc;
  logic        lk_hit, lk_taken;
  logic [31:0] lk_target;
  logic        upd_en, upd_taken, upd_mispred, flush;
  logic [31:0] upd_pc, upd_target;
  logic [15:0] upd_cnt, mispred_cnt;

  logic        lk_hit2, lk_taken2;
  logic [31:0] lk_target2;
  logic [1:0]  upd_cnt2, mispred_cnt2;

  int n_vec = 0;
  int n_mis = 0;
  int exp_upd = 0;
  int exp_mis = 0;

  always #5 clk = ~clk;

  branch_target_buffer #(.ADDR_W(32), .ENTRIES(16), .STAT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .lk_pc(lk_pc), .lk_hit(lk_hit),
    .lk_taken(lk_taken), .lk_target(lk_target), .upd_en(upd_en),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispred(upd_mispred), .flush(flush), .upd_cnt(upd_cnt),
    .mispred_cnt(mispred_cnt)
  );

  branch_target_buffer #(.ADDR_W(32), .ENTRIES(16), .STAT_W(2)) dut_s2 (
    .clk(clk), .rst_n(rst_n), .lk_pc(lk_pc), .lk_hit(lk_hit2),
    .lk_taken(lk_taken2), .lk_target(lk_target2), .upd_en(upd_en),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispred(upd_mispred), .flush(flush), .upd_cnt(upd_cnt2),
    .mispred_cnt(mispred_cnt2)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Lookup is combinational; settle briefly then compare all three outputs.
  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic taken, input logic [31:0] tgt);
    lk_pc = pc;
    #1;
    check_val({tag, ".hit"}, {31'd0, lk_hit}, {31'd0, hit});
    check_val({tag, ".taken"}, {31'd0, lk_taken}, {31'd0, taken});
    check_val({tag, ".target"}, lk_target, tgt);
  endtask

  // One update strobe across one rising edge; inputs change 1 ns after the edge.
  task automatic upd(input logic [31:0] pc, input logic taken,
                     input logic [31:0] tgt, input logic mis, input logic fl);
    upd_en = 1'b1; upd_pc = pc; upd_taken = taken; upd_target = tgt;
    upd_mispred = mis; flush = fl;
    @(posedge clk); #1;
    upd_en = 1'b0; flush = 1'b0; upd_mispred = 1'b0;
    exp_upd++;
    if (mis) exp_mis++;
  endtask

  initial begin
    rst_n = 1'b0; lk_pc = 32'h24; flush = 1'b0;
    upd_en = 1'b1; upd_pc = 32'h24; upd_taken = 1'b1; upd_target = 32'h10;
    upd_mispred = 1'b1;

    // Updates presented during reset must be ignored.
    repeat (2) @(posedge clk);
    #1;
    look("in_reset", 32'h24, 1'b0, 1'b0, 32'h0);
    upd_en = 1'b0; upd_mispred = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("rst.upd_cnt", {16'd0, upd_cnt}, 32'd0);
    check_val("rst.mispred_cnt", {16'd0, mispred_cnt}, 32'd0);
    look("cold_miss", 32'h24, 1'b0, 1'b0, 32'h0);

    // Allocate; lookup in the same cycle still sees the old (empty) entry.
    upd_en = 1'b1; upd_pc = 32'h24; upd_taken = 1'b1; upd_target = 32'h10;
    #1;
    check_val("rdw_no_bypass", {31'd0, lk_hit}, 32'd0);
    upd_en = 1'b0;
    upd(32'h24, 1'b1, 32'h10, 1'b1, 1'b0);
    look("alloc", 32'h24, 1'b1, 1'b1, 32'h10);

    // Counter: 10 -> 11 (x4, saturates), last taken overwrites target.
    upd(32'h24, 1'b1, 32'h10, 1'b0, 1'b0);
    upd(32'h24, 1'b1, 32'h10, 1'b0, 1'b0);
    upd(32'h24, 1'b1, 32'h10, 1'b0, 1'b0);
    upd(32'h24, 1'b1, 32'h14, 1'b0, 1'b0);
    look("sat_hi", 32'h24, 1'b1, 1'b1, 32'h14);
    upd(32'h24, 1'b0, 32'h77, 1'b1, 1'b0);
    look("nt_to_10", 32'h24, 1'b1, 1'b1, 32'h14);
    upd(32'h24, 1'b0, 32'h77, 1'b0, 1'b0);
    look("nt_to_01", 32'h24, 1'b1, 1'b0, 32'h14);
    upd(32'h24, 1'b0, 32'h77, 1'b0, 1'b0);
    look("nt_to_00", 32'h24, 1'b1, 1'b0, 32'h14);
    upd(32'h24, 1'b0, 32'h77, 1'b0, 1'b0);
    look("sat_lo", 32'h24, 1'b1, 1'b0, 32'h14);
    upd(32'h24, 1'b1, 32'h18, 1'b1, 1'b0);
    look("00_to_01", 32'h24, 1'b1, 1'b0, 32'h18);

    // Aliasing: 0x64 shares index 9 with 0x24 and evicts it.
    upd(32'h64, 1'b1, 32'h80, 1'b0, 1'b0);
    look("alias_old", 32'h24, 1'b0, 1'b0, 32'h0);
    look("alias_new", 32'h64, 1'b1, 1'b1, 32'h80);
    upd(32'h24, 1'b0, 32'h55, 1'b0, 1'b0);
    look("alias_nt_miss", 32'h64, 1'b1, 1'b1, 32'h80);
    look("low_bits_ignored", 32'h67, 1'b1, 1'b1, 32'h80);

    // Not-taken miss on an empty entry allocates nothing.
    check_val("pre_nt.upd_cnt", {16'd0, upd_cnt}, exp_upd);
    upd(32'h30, 1'b0, 32'h44, 1'b0, 1'b0);
    look("nt_miss", 32'h30, 1'b0, 1'b0, 32'h0);
    check_val("nt_miss.upd_cnt", {16'd0, upd_cnt}, exp_upd);

    // Flush wins over a same-cycle taken update; stats still count.
    upd(32'h40, 1'b1, 32'h99, 1'b1, 1'b1);
    look("flush_64", 32'h64, 1'b0, 1'b0, 32'h0);
    look("flush_40", 32'h40, 1'b0, 1'b0, 32'h0);
    check_val("flush.upd_cnt", {16'd0, upd_cnt}, exp_upd);
    check_val("flush.mispred_cnt", {16'd0, mispred_cnt}, exp_mis);

    // Stats saturation on the STAT_W=2 instance after a clean reset.
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    exp_upd = 0; exp_mis = 0;
    check_val("s2.reset_upd", {30'd0, upd_cnt2}, 32'd0);
    check_val("s2.reset_mis", {30'd0, mispred_cnt2}, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) upd(32'h100, 1'b1, 32'h200, 1'b1, 1'b0);
    check_val("s2.upd_sat", {30'd0, upd_cnt2}, 32'd3);
    check_val("s2.mis_sat", {30'd0, mispred_cnt2}, 32'd3);
    check_val("main.upd_cnt", {16'd0, upd_cnt}, exp_upd);
    look("pre_rst_hit", 32'h100, 1'b1, 1'b1, 32'h200);

    // Asynchronous reset between edges clears state immediately.
    #2 rst_n = 1'b0;
    #1;
    check_val("async.upd_cnt2", {30'd0, upd_cnt2}, 32'd0);
    check_val("async.mis_cnt2", {30'd0, mispred_cnt2}, 32'd0);
    check_val("async.upd_cnt", {16'd0, upd_cnt}, 32'd0);
    check_val("async.hit", {31'd0, lk_hit}, 32'd0);
    check_val("async.target", lk_target, 32'd0);
    upd_en = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_mispred = 1'b1;
    @(posedge clk); #1;
    upd_en = 1'b0; upd_mispred = 1'b0;
    rst_n = 1'b1;
    #1;
    look("post_rst", 32'h100, 1'b0, 1'b0, 32'h0);
    check_val("post_rst.upd_cnt", {16'd0, upd_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
